// File: rtl/ehl_generic2apb.sv
// ehl_generic2apb: APB3 initiator driven by the generic single-transfer
// command interface. Sequences IDLE -> SETUP -> ACCESS, handles wait
// states, aborts a hung ACCESS phase after TIMEOUT cycles, and returns a
// one-cycle response pulse with error flag and read data.
//
// Handshake: a command transfers on any pclk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. The requester
// holds cmd_valid and the command fields stable until that edge.
// rsp_valid is a single-cycle pulse; rsp_err and rsp_rdata hold until the
// next pulse.
module ehl_generic2apb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 6,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADR_WIDTH-1:0]  cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADR_WIDTH-1:0]  paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A zero TIMEOUT disables the abort path; keep the counter 1 bit wide
    // so the declarations stay legal and let it sit at zero.
    localparam bit                TO_EN    = (TIMEOUT > 0);
    localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]            state_q,     state_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADR_WIDTH-1:0]  paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  busy_q,      busy_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    // Next-state logic for the APB sequencer, response and wait counter.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_adr;
                    pwrite_d = cmd_write;
                    // Reads leave pwdata untouched so the bus does not toggle.
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                    psel_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    // Normal completion wins over a timeout in the same cycle.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset drops psel/penable immediately and discards
    // any transfer in flight without a response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_ehl_generic2apb.sv
// Directed bench for ehl_generic2apb with TIMEOUT=4. Inputs change and
// outputs are checked 1 ns after each rising edge; "cycle N" below counts
// rising edges since the cycle in which the command was presented.
module tb_ehl_generic2apb;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_adr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [5:0]  paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int tests_run;
    int tests_failed;

    ehl_generic2apb #(
        .DATA_WIDTH (32),
        .ADR_WIDTH  (6),
        .TIMEOUT    (4)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_adr   (cmd_adr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic wr, input logic [5:0] adr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_adr   = adr;
        cmd_wdata = wd;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_adr   = '0;
        cmd_wdata = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        prdata    = '0;

        // ---- reset values ----
        tick();
        tick();
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_paddr", paddr, 6'h00);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        presetn = 1'b1;
        tick();

        // ---- write, zero wait states ----
        present(1'b1, 6'h08, 32'hA5A5_0001);
        chk("wr0_c0_ready", cmd_ready, 1'b1);
        chk("wr0_c0_psel", psel, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("wr0_c1_psel", psel, 1'b1);
        chk("wr0_c1_penable", penable, 1'b0);
        chk("wr0_c1_paddr", paddr, 6'h08);
        chk("wr0_c1_pwrite", pwrite, 1'b1);
        chk("wr0_c1_pwdata", pwdata, 32'hA5A5_0001);
        chk("wr0_c1_busy", busy, 1'b1);
        chk("wr0_c1_ready", cmd_ready, 1'b0);
        tick();
        chk("wr0_c2_psel", psel, 1'b1);
        chk("wr0_c2_penable", penable, 1'b1);
        chk("wr0_c2_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk("wr0_c3_psel", psel, 1'b0);
        chk("wr0_c3_penable", penable, 1'b0);
        chk("wr0_c3_rsp_valid", rsp_valid, 1'b1);
        chk("wr0_c3_rsp_err", rsp_err, 1'b0);
        chk("wr0_c3_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr0_c3_busy", busy, 1'b0);
        chk("wr0_c3_ready", cmd_ready, 1'b1);
        tick();
        chk("wr0_c4_rsp_valid", rsp_valid, 1'b0);
        chk("wr0_c4_pwdata_hold", pwdata, 32'hA5A5_0001);
        chk("wr0_c4_paddr_hold", paddr, 6'h08);

        // ---- read, 3 wait states; bus noise ignored while pready=0 ----
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
        present(1'b0, 6'h14, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        chk("rd3_c1_paddr", paddr, 6'h14);
        chk("rd3_c1_pwrite", pwrite, 1'b0);
        chk("rd3_c1_pwdata_hold", pwdata, 32'hA5A5_0001);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("rd3_c%0d_psel", c), psel, 1'b1);
            chk($sformatf("rd3_c%0d_penable", c), penable, 1'b1);
            chk($sformatf("rd3_c%0d_paddr", c), paddr, 6'h14);
            chk($sformatf("rd3_c%0d_rsp_valid", c), rsp_valid, 1'b0);
        end
        tick();
        // cycle 5: 4th ACCESS cycle, also the timeout cycle; completion wins
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h1234_5678;
        chk("rd3_c5_psel", psel, 1'b1);
        chk("rd3_c5_paddr", paddr, 6'h14);
        tick();
        chk("rd3_c6_rsp_valid", rsp_valid, 1'b1);
        chk("rd3_c6_rsp_err", rsp_err, 1'b0);
        chk("rd3_c6_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd3_c6_psel", psel, 1'b0);
        tick();
        chk("rd3_c7_rdata_hold", rsp_rdata, 32'h1234_5678);

        // ---- slave error on read ----
        pslverr = 1'b1;
        prdata  = 32'hCAFE_F00D;
        present(1'b0, 6'h0C, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("err_c3_rsp_valid", rsp_valid, 1'b1);
        chk("err_c3_rsp_err", rsp_err, 1'b1);
        chk("err_c3_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        pslverr = 1'b0;
        tick();
        chk("err_c4_rsp_valid", rsp_valid, 1'b0);
        chk("err_c4_err_hold", rsp_err, 1'b1);

        // ---- timeout: pready held low for 4 ACCESS cycles ----
        pready = 1'b0;
        prdata = 32'h7777_7777;
        present(1'b0, 6'h20, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        // cycle 5: 4th ACCESS cycle
        chk("to_c5_psel", psel, 1'b1);
        chk("to_c5_penable", penable, 1'b1);
        chk("to_c5_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk("to_c6_psel", psel, 1'b0);
        chk("to_c6_penable", penable, 1'b0);
        chk("to_c6_rsp_valid", rsp_valid, 1'b1);
        chk("to_c6_rsp_err", rsp_err, 1'b1);
        chk("to_c6_rsp_rdata", rsp_rdata, 32'h0);
        chk("to_c6_ready", cmd_ready, 1'b1);
        pready = 1'b1;
        tick();
        chk("to_c7_rsp_valid", rsp_valid, 1'b0);

        // ---- following clean write clears rsp_err ----
        present(1'b1, 6'h10, 32'h0000_0055);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("clr_c3_rsp_valid", rsp_valid, 1'b1);
        chk("clr_c3_rsp_err", rsp_err, 1'b0);
        chk("clr_c3_rsp_rdata", rsp_rdata, 32'h0);
        tick();

        // ---- back-to-back: write 0, write 4, read 8 ----
        prdata = 32'h0BAD_F00D;
        present(1'b1, 6'h00, 32'h1111_1111);
        tick();
        chk("b2b_c1_paddr", paddr, 6'h00);
        chk("b2b_c1_pwdata", pwdata, 32'h1111_1111);
        present(1'b1, 6'h04, 32'h2222_2222);
        tick();
        chk("b2b_c2_ready", cmd_ready, 1'b0);
        tick();
        chk("b2b_c3_rsp_valid", rsp_valid, 1'b1);
        chk("b2b_c3_ready", cmd_ready, 1'b1);
        tick();
        chk("b2b_c4_psel", psel, 1'b1);
        chk("b2b_c4_penable", penable, 1'b0);
        chk("b2b_c4_paddr", paddr, 6'h04);
        chk("b2b_c4_pwdata", pwdata, 32'h2222_2222);
        chk("b2b_c4_rsp_valid", rsp_valid, 1'b0);
        present(1'b0, 6'h08, 32'h3333_3333);
        tick();
        chk("b2b_c5_penable", penable, 1'b1);
        tick();
        chk("b2b_c6_rsp_valid", rsp_valid, 1'b1);
        chk("b2b_c6_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_c7_psel", psel, 1'b1);
        chk("b2b_c7_paddr", paddr, 6'h08);
        chk("b2b_c7_pwrite", pwrite, 1'b0);
        chk("b2b_c7_pwdata_hold", pwdata, 32'h2222_2222);
        tick();
        tick();
        chk("b2b_c9_rsp_valid", rsp_valid, 1'b1);
        chk("b2b_c9_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("b2b_c9_pwdata_hold", pwdata, 32'h2222_2222);
        tick();

        // ---- reset asserted mid-ACCESS ----
        pready = 1'b0;
        present(1'b0, 6'h3C, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mrst_c3_psel", psel, 1'b1);
        chk("mrst_c3_penable", penable, 1'b1);
        presetn = 1'b0;
        #1;
        chk("mrst_async_psel", psel, 1'b0);
        chk("mrst_async_penable", penable, 1'b0);
        chk("mrst_async_busy", busy, 1'b0);
        chk("mrst_async_ready", cmd_ready, 1'b1);
        tick();
        presetn = 1'b1;
        pready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mrst_post%0d_rsp_valid", c), rsp_valid, 1'b0);
            chk($sformatf("mrst_post%0d_psel", c), psel, 1'b0);
            chk($sformatf("mrst_post%0d_ready", c), cmd_ready, 1'b1);
        end

        // ---- normal transfer after reset recovery ----
        present(1'b1, 6'h2A, 32'h5A5A_5A5A);
        tick();
        cmd_valid = 1'b0;
        chk("rec_c1_paddr", paddr, 6'h2A);
        chk("rec_c1_pwdata", pwdata, 32'h5A5A_5A5A);
        tick();
        tick();
        chk("rec_c3_rsp_valid", rsp_valid, 1'b1);
        chk("rec_c3_rsp_err", rsp_err, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ehl_generic2apb.md
Name: ehl_generic2apb

Overview:
APB3 initiator that converts the team's generic single-transfer command interface into APB transfers on a downstream APB bus. It is the mirror of the APB-to-generic target bridge used in front of peripherals such as the GPIO block. It lets an internal master (test controller, DMA, boot sequencer) program APB peripherals. The block provides the full SETUP/ACCESS sequencing, wait-state handling, a bus-hang timeout, and a one-cycle response pulse back to the requester.

Parameters:
DATA_WIDTH, 32, width of cmd_wdata/rsp_rdata/pwdata/prdata
ADR_WIDTH, 6, width of cmd_adr/paddr
TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  input  1  single clock for all logic
presetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_adr  input  ADR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  1  completion with error (pslverr or timeout); valid with rsp_valid
rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid
busy  output  1  transfer in progress (state != IDLE)
paddr  output  ADR_WIDTH  APB address
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB enable
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  APB target ready
pslverr  input  1  APB target error
prdata  input  DATA_WIDTH  APB read data

Behaviour:
- Interface: one clock, pclk; reset presetn is asynchronous and active-low.
- Reset values: state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata, busy all 0; cmd_ready 1.
- Reset asserted mid-transfer aborts immediately:
  - psel and penable drop asynchronously.
  - No rsp_valid is issued for the aborted command.
- FSM states:
  - IDLE: cmd_ready=1. When cmd_valid is high, register cmd_adr into paddr and cmd_write into pwrite. Register cmd_wdata into pwdata only when cmd_write=1; otherwise pwdata holds its previous value. Set psel=1 and go to SETUP.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS with penable=1.
  - ACCESS: psel=1, penable=1. Sample pready each cycle.
    - pready=1: clear psel and penable, go to IDLE. Next cycle rsp_valid=1 and rsp_err=pslverr. rsp_rdata = prdata for reads, 0 for writes.
    - pready=0: increment the wait counter.
- Timeout (TIMEOUT>0):
  - If pready is still 0 in the TIMEOUT-th ACCESS cycle, abort at the end of that cycle: clear psel and penable, go to IDLE.
  - Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If pready=1 in that same cycle, normal completion wins.
  - Counter width is clog2(TIMEOUT+1). The counter clears on every entry to SETUP.
- TIMEOUT=0: the block waits for pready indefinitely.
- paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle. They hold their values after completion; there is no toggling when idle.
- rsp_valid is a single-cycle pulse. rsp_err and rsp_rdata hold their values until the next rsp_valid.
- cmd_ready is combinational: state==IDLE. Commands presented while not in IDLE are not accepted; the requester must hold cmd_valid and its fields stable.
- Latency with zero wait states:
  - Accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - The next command can be accepted at cycle 3, giving a peak throughput of one transfer per 3 cycles.
- Each wait state adds 1 cycle.
- busy = (state != IDLE), registered with the state.
- pslverr and prdata are ignored outside ACCESS and in ACCESS cycles with pready=0.

Test Plan:
- Write, zero wait: cmd_adr=6'h08, cmd_wdata=32'hA5A5_0001, pready tied 1 -> psel high cycles 1-2, penable high cycle 2 only, pwdata=A5A50001; rsp_valid at cycle 3 with rsp_err=0.
- Read, 3 wait states: cmd_adr=6'h14, prdata=32'h1234_5678 returned with pready on the 4th ACCESS cycle -> paddr stable throughout, rsp_valid at cycle 6, rsp_rdata=12345678.
- Slave error: read with pslverr=1 and pready=1 -> rsp_valid=1, rsp_err=1; the following transfer with pslverr=0 gives rsp_err=0.
- Timeout: TIMEOUT=4, pready held 0 -> psel drops after the 4th ACCESS cycle, rsp_err=1, rsp_rdata=0; pready rising in the 4th ACCESS cycle instead gives a normal completion.
- Back-to-back: cmd_valid held high for two writes (adr 0, 4) -> second SETUP starts cycle 4, no idle APB cycle lost beyond the FSM, both rsp_valid pulses present; pwdata unchanged across an interleaved read.
- Reset mid-ACCESS: presetn low during wait -> psel and penable 0 immediately, no rsp_valid, cmd_ready 1 after release.
